// File: rtl/cmac_tx_axis_arbiter_if.sv
// cmac_tx_axis_arbiter_if
//   One AXI-Stream link (tvalid/tready/tlast + tdata/tkeep/tuser) as used by the
//   CMAC TX arbiter for both requester ports and the merged CMAC-facing port.
//   master: drives tvalid/tlast/tdata/tkeep/tuser, samples tready
//   slave : samples tvalid/tlast/tdata/tkeep/tuser, drives tready
interface cmac_tx_axis_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/cmac_tx_axis_arbiter.sv
// cmac_tx_axis_arbiter
//   Packet-granular round-robin arbiter sharing one CMAC TX AXI-Stream channel
//   between port 0 (XDMA H2C passthrough) and port 1 (UDP perf generator).
//   A granted port owns the channel until its tlast beat transfers; the merged
//   stream passes through a single output register stage.
//
// Ports
//   xdma_clk, xdma_reset : clock, async active-high reset
//   s0_axis, s1_axis     : requester streams (slave modport)
//   m_axis               : CMAC TX stream (master modport), registered
//   port_en[1:0]         : per-port enable for new grants
//   grant[1:0]           : one-hot current owner, 0 when idle
//   busy                 : grant != 0 or output register holds a beat
//   pkt_cnt0/pkt_cnt1    : packets forwarded per port
//
// Build option
//   CMAC_TX_ARB_PKT_CNT_EN : when defined, pkt_cnt0/1 count tlast beats leaving
//   m_axis per source port (wrapping); otherwise they are tied to zero.
module cmac_tx_axis_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic        xdma_clk,
  input  logic        xdma_reset,
  cmac_tx_axis_arbiter_if.slave  s0_axis,
  cmac_tx_axis_arbiter_if.slave  s1_axis,
  cmac_tx_axis_arbiter_if.master m_axis,
  input  logic [1:0]  port_en,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;

  logic [NUM_PORTS-1:0]                 s_vld, s_last, s_rdy, cand;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0] s_keep;
  logic [NUM_PORTS-1:0][USER_WIDTH-1:0] s_user;

  logic sel, out_rdy, acc, acc_last;

  logic                  m_vld;
  logic                  q_last;
  logic [DATA_WIDTH-1:0] q_data;
  logic [KEEP_WIDTH-1:0] q_keep;
  logic [USER_WIDTH-1:0] q_user;

  assign s_vld  = {s1_axis.tvalid, s0_axis.tvalid};
  assign s_last = {s1_axis.tlast,  s0_axis.tlast};
  assign s_data = {s1_axis.tdata,  s0_axis.tdata};
  assign s_keep = {s1_axis.tkeep,  s0_axis.tkeep};
  assign s_user = {s1_axis.tuser,  s0_axis.tuser};

  assign cand  = s_vld & port_en;
  assign grant = {state == GRANT1, state == GRANT0};
  assign sel   = (state == GRANT1);

  // tready is a function of registered state and m_axis.tready only, never of
  // s_*_tvalid, so no combinational path runs from requester valid to ready.
  assign out_rdy        = ~m_vld | m_axis.tready;
  assign s_rdy          = grant & {NUM_PORTS{out_rdy}};
  assign s0_axis.tready = s_rdy[0];
  assign s1_axis.tready = s_rdy[1];

  assign acc      = |(s_vld & s_rdy);
  assign acc_last = acc & s_last[sel];

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // port 0 wins the first tie
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Handoff on tlast uses c[] of the same cycle: the other port first, then the
  // current one, so a busy peer always gets the next packet without a bubble.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (&cand)        state_nxt = last_grant ? GRANT0 : GRANT1;
        else if (cand[0]) state_nxt = GRANT0;
        else if (cand[1]) state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (acc_last) begin
          last_grant_nxt = sel;
          if (cand[~sel])     state_nxt = sel ? GRANT0 : GRANT1;
          else if (cand[sel]) state_nxt = state;
          else                state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: loads on accept, drains on m_axis.tready, holds on stall.
  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      m_vld  <= 1'b0;
      q_last <= 1'b0;
      q_data <= '0;
      q_keep <= '0;
      q_user <= '0;
    end else if (acc) begin
      m_vld  <= 1'b1;
      q_last <= s_last[sel];
      q_data <= s_data[sel];
      q_keep <= s_keep[sel];
      q_user <= s_user[sel];
    end else if (m_axis.tready) begin
      m_vld  <= 1'b0;
    end
  end

  assign m_axis.tvalid = m_vld;
  assign m_axis.tlast  = q_last;
  assign m_axis.tdata  = q_data;
  assign m_axis.tkeep  = q_keep;
  assign m_axis.tuser  = q_user;

  assign busy = (|grant) | m_vld;

`ifdef CMAC_TX_ARB_PKT_CNT_EN
  // Source port rides alongside the payload so the count lands on the port
  // that owned the beat, even after the grant has moved on.
  logic        q_src;
  logic [31:0] cnt [NUM_PORTS];

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      q_src <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      if (acc) q_src <= sel;
      for (int i = 0; i < NUM_PORTS; i++)
        if (m_vld && m_axis.tready && q_last && (q_src == 1'(i)))
          cnt[i] <= cnt[i] + 32'd1;
    end
  end

  assign pkt_cnt0 = cnt[0];
  assign pkt_cnt1 = cnt[1];
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
module tb_cmac_tx_axis_arbiter;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;
`ifdef CMAC_TX_ARB_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic xdma_clk = 1'b0;
  logic xdma_reset = 1'b1;
  always #5 xdma_clk = ~xdma_clk;

  cmac_tx_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s0_axis ();
  cmac_tx_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s1_axis ();
  cmac_tx_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_axis ();

  logic [1:0]  port_en;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] pkt_cnt0, pkt_cnt1;

  cmac_tx_axis_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .xdma_clk   (xdma_clk),
    .xdma_reset (xdma_reset),
    .s0_axis    (s0_axis),
    .s1_axis    (s1_axis),
    .m_axis     (m_axis),
    .port_en    (port_en),
    .grant      (grant),
    .busy       (busy),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;
  typedef struct packed {
    beat_t b;
    logic  src;
  } exp_t;

  beat_t q0[$], q1[$];   // pending stimulus per port
  exp_t  sb[$];          // scoreboard: beats accepted on s-side, awaiting m-side
  int    order[$];       // source port of each packet completed on m_axis
  int    errors = 0, checks = 0;
  int    take0, take1, mbeats, ecnt0, ecnt1;
  int    pkt_id [2] = '{0, 0};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int p, input int id, input int k, input bit last);
    beat_t b;
    logic [31:0] w;
    w      = {8'(p), 8'(id), 16'(k)};
    b.data = {16{w}};
    b.keep = last ? {32'h0, 32'hFFFF_FFFF} : '1;
    b.user = 1'(k & 1);
    b.last = last;
    return b;
  endfunction

  task automatic add_pkt(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (p == 0) q0.push_back(mk(p, pkt_id[p], k, k == n - 1));
      else        q1.push_back(mk(p, pkt_id[p], k, k == n - 1));
    end
    pkt_id[p]++;
  endtask

  // Stimulus pump + scoreboard monitor. Handshakes are observed mid-cycle and
  // the next beat is presented just after the edge that consumed the last one.
  initial begin
    bit t0, t1;
    exp_t e;
    s0_axis.tvalid = 0; s0_axis.tlast = 0; s0_axis.tdata = '0; s0_axis.tkeep = '0; s0_axis.tuser = '0;
    s1_axis.tvalid = 0; s1_axis.tlast = 0; s1_axis.tdata = '0; s1_axis.tkeep = '0; s1_axis.tuser = '0;
    forever begin
      @(negedge xdma_clk);
      t0 = s0_axis.tvalid && s0_axis.tready;
      t1 = s1_axis.tvalid && s1_axis.tready;
      if (t0) begin e.b = q0[0]; e.src = 1'b0; sb.push_back(e); take0++; end
      if (t1) begin e.b = q1[0]; e.src = 1'b1; sb.push_back(e); take1++; end
      if (m_axis.tvalid && m_axis.tready) begin
        mbeats++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("m_tdata", m_axis.tdata, e.b.data);
          chk("m_tkeep", m_axis.tkeep, e.b.keep);
          chk("m_tuser", m_axis.tuser, e.b.user);
          chk("m_tlast", m_axis.tlast, e.b.last);
          if (e.b.last) begin
            order.push_back(int'(e.src));
            if (e.src) ecnt1++; else ecnt0++;
          end
        end
      end
      @(posedge xdma_clk);
      #1;
      if (t0 && q0.size() > 0) void'(q0.pop_front());
      if (t1 && q1.size() > 0) void'(q1.pop_front());
      s0_axis.tvalid = (q0.size() > 0);
      if (q0.size() > 0) begin
        s0_axis.tdata = q0[0].data; s0_axis.tkeep = q0[0].keep;
        s0_axis.tuser = q0[0].user; s0_axis.tlast = q0[0].last;
      end else begin
        s0_axis.tdata = '0; s0_axis.tkeep = '0; s0_axis.tuser = '0; s0_axis.tlast = 0;
      end
      s1_axis.tvalid = (q1.size() > 0);
      if (q1.size() > 0) begin
        s1_axis.tdata = q1[0].data; s1_axis.tkeep = q1[0].keep;
        s1_axis.tuser = q1[0].user; s1_axis.tlast = q1[0].last;
      end else begin
        s1_axis.tdata = '0; s1_axis.tkeep = '0; s1_axis.tuser = '0; s1_axis.tlast = 0;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_m_tvalid", m_axis.tvalid, 0);
    chk("rst_m_tdata",  m_axis.tdata, 0);
    chk("rst_m_tkeep",  m_axis.tkeep, 0);
    chk("rst_m_tuser",  m_axis.tuser, 0);
    chk("rst_m_tlast",  m_axis.tlast, 0);
    chk("rst_grant",    grant, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_s0_tready", s0_axis.tready, 0);
    chk("rst_s1_tready", s1_axis.tready, 0);
    chk("rst_pkt_cnt0", pkt_cnt0, 0);
    chk("rst_pkt_cnt1", pkt_cnt1, 0);
  endtask

  task automatic do_reset();
    @(posedge xdma_clk); #2;
    xdma_reset = 1'b1;
    #1 check_reset_vals();
    q0.delete(); q1.delete(); sb.delete(); order.delete();
    take0 = 0; take1 = 0; mbeats = 0; ecnt0 = 0; ecnt1 = 0;
    @(posedge xdma_clk); #2;
    xdma_reset = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge xdma_clk);
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || m_axis.tvalid) && n < 300) begin
      @(negedge xdma_clk);
      n++;
    end
    if (n >= 300) chk(tag, 1, 0);
  endtask

  initial begin
    int n, gaps, pid;
    logic [DW-1:0] held;
    port_en = 2'b11;
    m_axis.tready = 1'b1;

    // ---- T1: single 4-beat port-0 packet, arbitration and datapath latency
    do_reset();
    pid = pkt_id[0];
    add_pkt(0, 4);
    @(posedge xdma_clk); #2;                 // cycle n: valid just raised
    chk("t1_s0_tvalid_n", s0_axis.tvalid, 1);
    chk("t1_grant_n", grant, 2'b00);
    @(posedge xdma_clk); #2;                 // n+1
    chk("t1_grant_n1", grant, 2'b01);
    chk("t1_s0_tready_n1", s0_axis.tready, 1);
    chk("t1_s1_tready_n1", s1_axis.tready, 0);
    chk("t1_m_tvalid_n1", m_axis.tvalid, 0);
    for (int k = 0; k < 4; k++) begin        // n+2 .. n+5
      @(posedge xdma_clk); #2;
      chk("t1_m_tvalid_beat", m_axis.tvalid, 1);
      chk("t1_m_tdata_beat", m_axis.tdata, mk(0, pid, k, k == 3).data);
      chk("t1_m_tlast_beat", m_axis.tlast, (k == 3));
    end
    @(posedge xdma_clk); #2;
    chk("t1_m_tvalid_after", m_axis.tvalid, 0);
    wait_drain("t1_drain_timeout");
    chk("t1_pkt_cnt0", pkt_cnt0, CNT_EN ? 1 : 0);
    chk("t1_pkt_cnt1", pkt_cnt1, 0);

    // ---- T2: both ports offering 3-beat packets back to back
    do_reset();
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(0, 3); add_pkt(1, 3);
    n = 0;
    @(negedge xdma_clk);
    while (!m_axis.tvalid && n < 50) begin @(negedge xdma_clk); n++; end
    if (n >= 50) chk("t2_start_timeout", 1, 0);
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      if (!m_axis.tvalid) gaps++;
      if (i < 11) @(negedge xdma_clk);
    end
    chk("t2_gaps", gaps, 0);
    wait_drain("t2_drain_timeout");
    chk("t2_npkts", order.size(), 4);
    if (order.size() == 4) begin
      chk("t2_order0", order[0], 0);
      chk("t2_order1", order[1], 1);
      chk("t2_order2", order[2], 0);
      chk("t2_order3", order[3], 1);
    end
    chk("t2_pkt_cnt0", pkt_cnt0, CNT_EN ? 2 : 0);
    chk("t2_pkt_cnt1", pkt_cnt1, CNT_EN ? 2 : 0);

    // ---- T3: port_en[1] drops mid-packet; packet completes, no re-grant
    do_reset();
    add_pkt(1, 5); add_pkt(1, 2);
    n = 0;
    while (take1 < 2 && n < 50) begin @(negedge xdma_clk); n++; end
    if (n >= 50) chk("t3_start_timeout", 1, 0);
    port_en = 2'b01;
    repeat (12) @(negedge xdma_clk);
    chk("t3_take1", take1, 5);
    chk("t3_q1_left", q1.size(), 2);
    chk("t3_grant", grant, 2'b00);
    chk("t3_busy", busy, 0);
    chk("t3_s1_tready", s1_axis.tready, 0);
    chk("t3_npkts", order.size(), 1);
    port_en = 2'b11;
    wait_drain("t3_drain_timeout");
    chk("t3_npkts_final", order.size(), 2);
    chk("t3_pkt_cnt1", pkt_cnt1, CNT_EN ? 2 : 0);

    // ---- T4: m_axis_tready 1,0,0,1 during a packet
    do_reset();
    pid = pkt_id[0];
    add_pkt(0, 4);
    n = 0;
    @(negedge xdma_clk);
    while (!m_axis.tvalid && n < 50) begin @(negedge xdma_clk); n++; end
    if (n >= 50) chk("t4_start_timeout", 1, 0);
    held = mk(0, pid, 1, 0).data;           // beat 1 is loaded when the stall begins
    @(posedge xdma_clk); #2;
    m_axis.tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge xdma_clk);
      chk("t4_stall_tvalid", m_axis.tvalid, 1);
      chk("t4_stall_tdata", m_axis.tdata, held);
      chk("t4_stall_s0_tready", s0_axis.tready, 0);
      if (i == 0) @(posedge xdma_clk);
    end
    @(posedge xdma_clk); #2;
    m_axis.tready = 1'b1;
    wait_drain("t4_drain_timeout");
    chk("t4_take0", take0, 4);
    chk("t4_mbeats", mbeats, 4);

    // ---- T5: reset mid-packet, then a 1-beat port-1 packet
    do_reset();
    add_pkt(0, 6);
    n = 0;
    while (take0 < 2 && n < 50) begin @(negedge xdma_clk); n++; end
    if (n >= 50) chk("t5_start_timeout", 1, 0);
    do_reset();
    add_pkt(1, 1);
    wait_drain("t5_drain_timeout");
    chk("t5_npkts", order.size(), 1);
    if (order.size() == 1) chk("t5_src", order[0], 1);
    chk("t5_pkt_cnt1", pkt_cnt1, CNT_EN ? 1 : 0);
    chk("t5_pkt_cnt0", pkt_cnt0, 0);
    chk("t5_ecnt0", ecnt0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
